// File: rtl/config_chain_loader.sv
// config_chain_loader: streams configuration words LSB-first into the ccff chain.
// Each word arrives on a valid/ready stream, is serialized one bit per clock onto
// ccff_head with prog_en qualifying the shift, and the load completes after
// exactly CHAIN_LEN bits. Surplus bits of the final word are never shifted.
// Optional feature macro: CONFIG_CHAIN_LOADER_CRC_EN enables a CRC-16-CCITT
// over the shifted bits; without it crc_out is tied to zero.
module config_chain_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              prog_en,
    output logic              busy,
    output logic              done,
    output logic [20:0]       bit_count,
    output logic [15:0]       crc_out
);

    localparam int WC_W = (WORD_W < 2) ? 1 : $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shreg_q;
    logic [WC_W-1:0]   word_cnt_q;
    logic              load_word;
    logic              shift_bit;
    logic              clear_cnt;
    logic              last_bit;
    logic              word_last;

    assign last_bit  = (bit_count == 21'(CHAIN_LEN - 1));
    assign word_last = (word_cnt_q == WC_W'(WORD_W - 1));
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);

    // State register.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and per-cycle control strobes; abort beats start while busy.
    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        load_word = 1'b0;
        shift_bit = 1'b0;
        clear_cnt = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    clear_cnt = 1'b1;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        load_word = 1'b1;
                        state_d   = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                // The bit on ccff_head is captured by the chain at this edge,
                // even when the load is being aborted.
                shift_bit = 1'b1;
                if (abort)          state_d = ST_IDLE;
                else if (last_bit)  state_d = ST_DONE;
                else if (word_last) state_d = ST_LOAD;
                else                state_d = ST_SHIFT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift datapath: the first bit of a word is presented straight from s_data
    // so prog_en rises in the cycle right after the handshake.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            shreg_q    <= '0;
            word_cnt_q <= '0;
            bit_count  <= '0;
            ccff_head  <= 1'b0;
            prog_en    <= 1'b0;
        end else begin
            if (load_word) begin
                shreg_q    <= s_data >> 1;
                word_cnt_q <= '0;
            end else if (shift_bit) begin
                shreg_q    <= shreg_q >> 1;
                word_cnt_q <= word_cnt_q + WC_W'(1);
            end

            if (clear_cnt)      bit_count <= '0;
            else if (shift_bit) bit_count <= bit_count + 21'd1;

            prog_en <= (state_d == ST_SHIFT);
            if (load_word)                 ccff_head <= s_data[0];
            else if (state_d == ST_SHIFT)  ccff_head <= shreg_q[0];
            else                           ccff_head <= 1'b0;
        end
    end

`ifdef CONFIG_CHAIN_LOADER_CRC_EN
    logic [15:0] crc_q;

    // One MSB-first CRC-16-CCITT step (poly 0x1021) for a single input bit.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // CRC over every bit driven with prog_en high; holds when not shifting.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN)          crc_q <= 16'h0000;
        else if (clear_cnt) crc_q <= 16'hFFFF;
        else if (shift_bit) crc_q <= crc_step(crc_q, ccff_head);
    end

    assign crc_out = crc_q;
`else
    assign crc_out = 16'h0000;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: CHAIN_LEN=20/WORD_W=8 instance for streaming,
// stall, abort, reset and ignored-start scenarios; CHAIN_LEN=8 instance for CRC.
module tb_config_chain_loader;

    logic        CK = 1'b0;
    logic        RSTN = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;

    logic        s_ready, ccff_head, prog_en, busy, done;
    logic [20:0] bit_count;
    logic [15:0] crc_out;
    logic        s_ready2, ccff_head2, prog_en2, busy2, done2;
    logic [20:0] bit_count2;
    logic [15:0] crc_out2;

    int total = 0;
    int bad = 0;
    logic [7:0] words [3] = '{8'hA5, 8'h3C, 8'hFF};

    config_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut (
        .CK(CK), .RSTN(RSTN), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ccff_head(ccff_head), .prog_en(prog_en), .busy(busy), .done(done),
        .bit_count(bit_count), .crc_out(crc_out)
    );

    config_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut2 (
        .CK(CK), .RSTN(RSTN), .start(start2), .abort(1'b0),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
        .ccff_head(ccff_head2), .prog_en(prog_en2), .busy(busy2), .done(done2),
        .bit_count(bit_count2), .crc_out(crc_out2)
    );

    always #5 CK = ~CK;

    // Drives one load of the three words; observes at negedge, drives for the next edge.
    task automatic stream(input int stall_word, input int stall_len, input int poke_at,
                          input int abort_at, output int pe_cnt, output logic [19:0] seen,
                          output int accepted, output bit finished);
        int widx;
        int stall_cnt;
        bit hs;
        widx = 0; stall_cnt = 0; hs = 0;
        pe_cnt = 0; seen = '0; accepted = 0; finished = 0;
        @(negedge CK); start = 1'b1;
        @(negedge CK); start = 1'b0;
        total++;
        if (s_ready !== 1'b1) begin
            bad++; $display("FAIL start_to_ready: s_ready=%b required 1", s_ready);
        end
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (hs) begin widx++; accepted++; end
            if (prog_en === 1'b1) begin
                if (pe_cnt < 20) seen[pe_cnt] = ccff_head;
                pe_cnt++;
            end
            if (done === 1'b1) begin finished = 1; break; end
            start = (poke_at != 0 && pe_cnt == poke_at && prog_en === 1'b1);
            if (abort_at != 0 && pe_cnt == abort_at) begin
                abort = 1'b1; s_valid = 1'b0;
                @(negedge CK); abort = 1'b0;
                break;
            end
            s_data = words[(widx < 3) ? widx : 0];
            if (widx < 3 && widx == stall_word && stall_cnt < stall_len) begin
                s_valid = 1'b0;
                if (stall_cnt > 0 || s_ready === 1'b1) begin
                    total++;
                    if (s_ready !== 1'b1 || prog_en !== 1'b0) begin
                        bad++; $display("FAIL stall_cycle%0d: s_ready=%b prog_en=%b required 1,0",
                                        stall_cnt, s_ready, prog_en);
                    end
                    stall_cnt++;
                end
            end else begin
                s_valid = (widx < 3);
            end
            #1; hs = s_valid && s_ready;
            @(negedge CK);
        end
        s_valid = 1'b0; start = 1'b0;
    endtask

    // Checks a completed 20-bit load.
    task automatic check_full_load(input string tag, input int pe_cnt, input logic [19:0] seen,
                                   input int accepted, input bit finished);
        total++;
        if (!finished) begin bad++; $display("FAIL %s_finished: done never seen", tag); end
        total++;
        if (pe_cnt != 20) begin bad++; $display("FAIL %s_prog_en_count: got %0d required 20", tag, pe_cnt); end
        total++;
        if (seen !== 20'hF3CA5) begin bad++; $display("FAIL %s_stream: got %h required F3CA5", tag, seen); end
        total++;
        if (accepted != 3) begin bad++; $display("FAIL %s_words: got %0d required 3", tag, accepted); end
        total++;
        if (bit_count !== 21'd20 || done !== 1'b1 || busy !== 1'b0 || prog_en !== 1'b0) begin
            bad++; $display("FAIL %s_end: bit_count=%0d done=%b busy=%b prog_en=%b required 20,1,0,0",
                            tag, bit_count, done, busy, prog_en);
        end
`ifndef CONFIG_CHAIN_LOADER_CRC_EN
        total++;
        if (crc_out !== 16'h0000) begin bad++; $display("FAIL %s_crc_tied: got %h required 0000", tag, crc_out); end
`endif
    endtask

    task automatic test_reset();
        @(negedge CK); @(negedge CK);
        total++;
        if ({s_ready, ccff_head, prog_en, busy, done, bit_count, crc_out} !== '0) begin
            bad++; $display("FAIL reset_dut: s_ready=%b head=%b prog_en=%b busy=%b done=%b cnt=%0d crc=%h required all 0",
                            s_ready, ccff_head, prog_en, busy, done, bit_count, crc_out);
        end
        total++;
        if ({s_ready2, prog_en2, busy2, done2, bit_count2, crc_out2} !== '0) begin
            bad++; $display("FAIL reset_dut2: s_ready=%b prog_en=%b cnt=%0d crc=%h required all 0",
                            s_ready2, prog_en2, bit_count2, crc_out2);
        end
        RSTN = 1'b1;
        @(negedge CK);
    endtask

    task automatic test_basic();
        int pe; logic [19:0] sn; int acc; bit fin;
        stream(-1, 0, 0, 0, pe, sn, acc, fin);
        check_full_load("basic", pe, sn, acc, fin);
    endtask

    task automatic test_stall();
        int pe; logic [19:0] sn; int acc; bit fin;
        stream(1, 5, 0, 0, pe, sn, acc, fin);
        check_full_load("stall", pe, sn, acc, fin);
    endtask

    task automatic test_start_ignored();
        int pe; logic [19:0] sn; int acc; bit fin;
        stream(-1, 0, 5, 0, pe, sn, acc, fin);
        check_full_load("start_in_shift", pe, sn, acc, fin);
    endtask

    task automatic test_abort();
        int pe; logic [19:0] sn; int acc; bit fin;
        stream(-1, 0, 0, 10, pe, sn, acc, fin);
        total++;
        if (busy !== 1'b0 || prog_en !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0) begin
            bad++; $display("FAIL abort_idle: busy=%b prog_en=%b done=%b s_ready=%b required 0,0,0,0",
                            busy, prog_en, done, s_ready);
        end
        total++;
        if (bit_count !== 21'd10) begin bad++; $display("FAIL abort_count: got %0d required 10", bit_count); end
        repeat (3) @(negedge CK);
        total++;
        if (bit_count !== 21'd10 || done !== 1'b0) begin
            bad++; $display("FAIL abort_hold: cnt=%0d done=%b required 10,0", bit_count, done);
        end
        start = 1'b1; @(negedge CK); start = 1'b0;
        total++;
        if (bit_count !== 21'd0 || s_ready !== 1'b1) begin
            bad++; $display("FAIL abort_restart: cnt=%0d s_ready=%b required 0,1", bit_count, s_ready);
        end
        abort = 1'b1; @(negedge CK); abort = 1'b0;
        total++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            bad++; $display("FAIL abort_in_load: busy=%b s_ready=%b required 0,0", busy, s_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_pe;
        seen_pe = 0;
        start = 1'b1; @(negedge CK); start = 1'b0;
        s_data = 8'hA5; s_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CK);
            if (prog_en === 1'b1) begin seen_pe = 1; break; end
        end
        s_valid = 1'b0;
        @(negedge CK);
        total++;
        if (!seen_pe || busy !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre: prog_en_seen=%0d busy=%b required 1,1", seen_pe, busy);
        end
        @(posedge CK); #2; RSTN = 1'b0; #1;
        total++;
        if ({s_ready, ccff_head, prog_en, busy, done, bit_count, crc_out} !== '0) begin
            bad++; $display("FAIL rstmid_async: s_ready=%b head=%b prog_en=%b busy=%b done=%b cnt=%0d crc=%h required all 0",
                            s_ready, ccff_head, prog_en, busy, done, bit_count, crc_out);
        end
        @(negedge CK); RSTN = 1'b1;
        @(negedge CK); @(negedge CK);
        total++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_needs_start: s_ready=%b busy=%b required 0,0", s_ready, busy);
        end
        start = 1'b1; @(negedge CK); start = 1'b0;
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: s_ready=%b required 1", s_ready); end
        abort = 1'b1; @(negedge CK); abort = 1'b0;
    endtask

    task automatic test_crc();
        int pe; int acc; bit hs;
        logic [15:0] exp_init, exp_final;
`ifdef CONFIG_CHAIN_LOADER_CRC_EN
        exp_init = 16'hFFFF; exp_final = 16'hE1F0;
`else
        exp_init = 16'h0000; exp_final = 16'h0000;
`endif
        pe = 0; acc = 0; hs = 0;
        start2 = 1'b1; @(negedge CK); start2 = 1'b0;
        total++;
        if (s_ready2 !== 1'b1 || crc_out2 !== exp_init) begin
            bad++; $display("FAIL crc_start: s_ready=%b crc=%h required 1,%h", s_ready2, crc_out2, exp_init);
        end
        s_data = 8'h00; s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1; hs = s_valid && s_ready2;
            @(negedge CK);
            if (hs) acc++;
            if (prog_en2 === 1'b1) pe++;
            if (done2 === 1'b1) break;
        end
        s_valid = 1'b0;
        total++;
        if (done2 !== 1'b1 || pe != 8 || acc != 1 || bit_count2 !== 21'd8) begin
            bad++; $display("FAIL crc_load: done=%b prog_en_cycles=%0d words=%0d cnt=%0d required 1,8,1,8",
                            done2, pe, acc, bit_count2);
        end
        total++;
        if (crc_out2 !== exp_final) begin bad++; $display("FAIL crc_value: got %h required %h", crc_out2, exp_final); end
        repeat (3) @(negedge CK);
        total++;
        if (crc_out2 !== exp_final) begin bad++; $display("FAIL crc_frozen: got %h required %h", crc_out2, exp_final); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_crc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Bitstream loader that sits directly upstream of the configuration flip-flop chain (the DFFR-based ccff chain).
- Accepts configuration words over a valid/ready stream.
- Serializes each word LSB-first onto the chain head, one bit per clock, qualified by a shift-enable.
- Counts bits to the exact chain length and signals completion; the fabric's programming controller uses this to load the fabric.

Parameters:
- CHAIN_LEN, 1024, number of flip-flops in the configuration chain (bits to shift); legal range 1 to 2^20.
- WORD_W, 8, width of input configuration words; legal range 1 to 64.

Ports:
- CK  input  1  clock; the same clock drives the configuration chain.
- RSTN  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- abort  input  1  cancels a load in progress.
- s_data  input  WORD_W  configuration word; bit 0 is shifted first.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts a word this cycle.
- ccff_head  output  1  serial data to the chain head.
- prog_en  output  1  chain shift enable; the chain captures ccff_head on CK when high.
- busy  output  1  high in LOAD or SHIFT.
- done  output  1  level; high in DONE.
- bit_count  output  21  bits shifted so far in the current load.
- crc_out  output  16  CRC of shifted bits (see Optional Feature).

Behaviour:
- Reset (RSTN low, asynchronous): state IDLE. s_ready, ccff_head, prog_en, busy and done are 0. bit_count and crc_out are 0. Shift register is cleared.
- States:
  - IDLE: start -> LOAD; bit_count cleared to 0 on that edge.
  - LOAD: s_ready=1. s_valid&&s_ready -> capture s_data into shift register, set word bit counter to 0, go to SHIFT.
  - SHIFT: s_ready=0. Each cycle, prog_en and ccff_head are registered outputs: ccff_head=shreg[0] and prog_en=1 in the same cycle. The shift register then shifts right and bit_count increments.
    - When bit_count reaches CHAIN_LEN -> DONE.
    - Otherwise, when WORD_W bits of the current word are used -> LOAD.
  - DONE: done=1, prog_en=0. start -> LOAD with bit_count cleared.
- Words needed = ceil(CHAIN_LEN/WORD_W). Bits of the final word beyond CHAIN_LEN are discarded, never driven with prog_en=1.
- Throughput: WORD_W shift cycles per word, plus at least 1 LOAD cycle per word (a bubble). prog_en is low during LOAD.
- Latency: start at cycle t -> s_ready high at t+1. A word accepted at edge e -> first prog_en=1 cycle immediately after e.
- Exactly CHAIN_LEN cycles have prog_en=1 per completed load.
- start while busy: ignored. abort while not busy: ignored.
- abort in LOAD or SHIFT: next state IDLE. prog_en=0 from the next cycle. Any partial word is dropped. done is not asserted. bit_count holds its last value until the next start.
- start and abort in the same cycle: abort wins if busy; otherwise start wins.
- s_valid while s_ready=0: the word is not consumed; the source must hold it.
- CHAIN_LEN=1: one word is accepted, a single prog_en cycle occurs, then DONE.
- RSTN asserted mid-load: all outputs go to reset values immediately. Chain contents are undefined and must be reloaded.

Optional Feature:
- Macro: CONFIG_CHAIN_LOADER_CRC_EN.
- Defined:
  - crc_out is a CRC-16-CCITT (polynomial 0x1021, init 0xFFFF, no reflection, no final XOR) updated once per prog_en=1 cycle with the ccff_head bit.
  - Reinitialised to 0xFFFF on start.
  - Frozen in DONE and after abort.
- Undefined: crc_out is tied to 16'h0000 and no CRC logic is synthesised. Port list is unchanged.

Test Plan:
- CHAIN_LEN=20, WORD_W=8, words 0xA5, 0x3C, 0xFF, s_valid always high -> 3 words accepted. prog_en high for exactly 20 cycles. ccff_head sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1. done rises; bit_count=20.
- Same config, s_valid low for 5 cycles before word 2 -> s_ready stays high; no prog_en during the stall. Serial stream is identical to the first test.
- abort after 10 prog_en cycles -> state IDLE next cycle, prog_en=0, done=0, bit_count=10. A new start restarts with bit_count=0.
- RSTN pulsed low mid-SHIFT -> all outputs 0 asynchronously. After release, start is required; s_ready=1 one cycle after start.
- start asserted during SHIFT -> ignored; total prog_en count remains 20.
- With CONFIG_CHAIN_LOADER_CRC_EN, CHAIN_LEN=8, word 0x00 -> crc_out equals the reference CRC-16-CCITT of eight 0 bits from init 0xFFFF, checked by the bench model. Without the macro -> crc_out=0x0000 throughout.
